cordic_sequencer: RTL and testbench
===================================

# cordic_sequencer

Multi-cycle controller that owns one combinational CORDIC iteration stage and drives it for a full CORDIC computation. Latches an operand set through a valid/ready input port, then feeds back the x/y/z registers once per cycle with the correct shift, angle constant and direction decision for circular, linear or hyperbolic mode, in rotation or vectoring sub-mode. Returns results on a valid/ready output port. Sits between the peripheral register file and the iteration datapath.

## Interface
- FIXED_WIDTH, 16, operand width; Q2.13 signed. Only 16 is supported; any other value is an elaboration error.
- ITERATIONS, 14, steps per computation, 1..14.
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- abort  in  1  synchronous; returns the block to IDLE, no result.
- in_valid  in  1  operand set offered.
- in_ready  out  1  high in IDLE only.
- in_mode  in  2  00 circular, 01 linear, 10 hyperbolic, 11 invalid.
- in_vectoring  in  1  0 rotation (drive z→0), 1 vectoring (drive y→0).
- in_x, in_y, in_z  in  FIXED_WIDTH  initial operands.
- out_valid  out  1  result held until accepted.
- out_ready  in  1  consumer accepts.
- out_x, out_y, out_z  out  FIXED_WIDTH  results.
- out_err  out  1  result is from an invalid mode.
- busy  out  1  high in RUN.

## Operation
- States: IDLE, RUN, DONE.
- IDLE: on in_valid, latch x/y/z/mode/vectoring and clear step counter.
  - Mode 11 goes to DONE with x=y=z=0 and out_err=1.
  - Any other mode goes to RUN.
- RUN: each cycle, load the stage outputs into x/y/z and increment the step. After step ITERATIONS-1, go to DONE.
- DONE: out_valid=1; outputs are the registers. On out_ready, go to IDLE.
- abort in RUN or DONE goes to IDLE. Registers keep their values; out_valid drops next cycle. abort has priority over out_ready and in_valid.
- in_valid outside IDLE is ignored; the source sees in_ready=0.
- Shift per step k=0..ITERATIONS-1:
  - Circular and linear: shift = k.
  - Hyperbolic: sequence 1,2,3,4,4,5,…,12,13. Index 4 repeats; the 13 repeat falls beyond 14 steps.
- Direction (sigma_pos):
  - Rotation: z ≥ 0.
  - Vectoring: y < 0.
  - The same rule applies in all modes.
- delta_z constants (Q2.13), taken from the effective shift i:
  - Circular, atan(2^-i): 6434, 3798, 2007, 1019, 511, 256, 128, 64, 32, 16, 8, 4, 2, 1.
  - Hyperbolic, atanh(2^-i), i≥1: 4500, 2092, 1029, 513, 256, 128, 64, 32, 16, 8, 4, 2, 1.
  - Linear: 8192 >> i.
- Arithmetic wraps at FIXED_WIDTH; there is no saturation. Gain compensation is the caller's job:
  - Circular: pre-scale x by K=0.60725 (4975).
  - Hyperbolic: pre-scale x by 1/Kh=1.2075 (9892).
- Vectoring assumes x>0. Results for other inputs are defined only as the wrapped register contents.

## Timing
- Reset values: state IDLE, in_ready=1, out_valid=0, busy=0, out_err=0, out_x=out_y=out_z=0, step=0.
- Accept edge is E0, where in_valid && in_ready.
- Iterations occur on edges E1..E_ITERATIONS.
- out_valid rises after E_ITERATIONS, giving latency ITERATIONS+1 cycles from acceptance.
- Invalid mode: out_valid after E0, latency 1.
- Back-to-back: a result accepted on edge F gives in_ready=1 after F. There is no same-edge DONE→accept of a new input.
- rst mid-RUN clears everything immediately, asynchronously.
- Outputs are registered; there is no combinational path from in_* to out_*.

## Structure
- Package cordic_pkg holds:
  - Mode constants (CIRCULAR_MODE, LINEAR_MODE, HYPERBOLIC_MODE).
  - State enum.
  - Q2.13 constant FRAC_BITS=13.
  - Functions for the atan/atanh/linear delta_z tables and the hyperbolic shift schedule.
- The existing CORDIC_iteration is instantiated once as the sole sub-module.
  - shift port width: $clog2(ITERATIONS)+1.
  - Its mode and is_sigma_positive inputs are driven from the latched mode and the direction rule.

## Test plan
- Circular rotation: x=4975, y=0, z=4289 (π/6) → out_x≈7094, out_y≈4096 ±12 LSB. out_valid exactly 15 cycles after accept.
- Circular vectoring: x=8192, y=8192, z=0 → out_z≈6434, out_x≈19078, out_y≈0 ±12.
- Linear vectoring: x=16384, y=8192, z=0 → out_z=4096 ±2, out_x=16384 exactly. Linear rotation: x=8192, z=12288 → out_y≈12288 ±2.
- Hyperbolic rotation: x=9892, y=0, z=4096 → out_x≈9237, out_y≈4269 ±16. Check via probe that the shift sequence contains 4 twice.
- Handshake and error:
  - Hold out_ready=0 for 5 cycles → outputs stable and in_ready=0.
  - in_valid pulsed during RUN → ignored.
  - in_mode=11 → out_err=1, out_valid after 1 cycle, outputs 0.
- Abort/reset:
  - abort at step 6 → IDLE next cycle, no out_valid.
  - rst asserted mid-RUN between edges → all outputs at reset values immediately.
  - A new operation afterwards is correct.

Source files
------------

// File: rtl/cordic_pkg.sv
// rtl/cordic_pkg.sv - shared constants, state encoding and CORDIC table helpers
package cordic_pkg;

    localparam int FRAC_BITS = 13;

    localparam logic [1:0] CIRCULAR_MODE   = 2'b00;
    localparam logic [1:0] LINEAR_MODE     = 2'b01;
    localparam logic [1:0] HYPERBOLIC_MODE = 2'b10;
    localparam logic [1:0] INVALID_MODE    = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    // atan(2^-i) in Q2.13
    function automatic logic [15:0] atan_delta(input logic [4:0] i);
        case (i)
            5'd0:    return 16'd6434;
            5'd1:    return 16'd3798;
            5'd2:    return 16'd2007;
            5'd3:    return 16'd1019;
            5'd4:    return 16'd511;
            5'd5:    return 16'd256;
            5'd6:    return 16'd128;
            5'd7:    return 16'd64;
            5'd8:    return 16'd32;
            5'd9:    return 16'd16;
            5'd10:   return 16'd8;
            5'd11:   return 16'd4;
            5'd12:   return 16'd2;
            5'd13:   return 16'd1;
            default: return 16'd0;
        endcase
    endfunction

    // atanh(2^-i) in Q2.13; i=0 is never scheduled
    function automatic logic [15:0] atanh_delta(input logic [4:0] i);
        case (i)
            5'd1:    return 16'd4500;
            5'd2:    return 16'd2092;
            5'd3:    return 16'd1029;
            5'd4:    return 16'd513;
            5'd5:    return 16'd256;
            5'd6:    return 16'd128;
            5'd7:    return 16'd64;
            5'd8:    return 16'd32;
            5'd9:    return 16'd16;
            5'd10:   return 16'd8;
            5'd11:   return 16'd4;
            5'd12:   return 16'd2;
            5'd13:   return 16'd1;
            default: return 16'd0;
        endcase
    endfunction

    // 2^-i in Q2.13
    function automatic logic [15:0] linear_delta(input logic [4:0] i);
        logic [15:0] one;
        one = 16'd1 << FRAC_BITS;
        return one >> i;
    endfunction

    // Hyperbolic schedule starts at 1 and repeats index 4 for convergence
    function automatic logic [4:0] hyp_shift(input logic [4:0] k);
        return (k <= 5'd3) ? k + 5'd1 : k;
    endfunction

endpackage

// File: rtl/cordic_iteration.sv
// rtl/cordic_iteration.sv - one combinational CORDIC micro-rotation
module cordic_iteration
    import cordic_pkg::*;
#(
    parameter int FIXED_WIDTH = 16,
    parameter int SHIFT_WIDTH = 5
) (
    input  logic signed [FIXED_WIDTH-1:0] x_i,
    input  logic signed [FIXED_WIDTH-1:0] y_i,
    input  logic signed [FIXED_WIDTH-1:0] z_i,
    input  logic        [SHIFT_WIDTH-1:0] shift_i,
    input  logic        [FIXED_WIDTH-1:0] delta_z_i,
    input  logic        [1:0]             mode_i,
    input  logic                          is_sigma_positive_i,
    output logic signed [FIXED_WIDTH-1:0] x_o,
    output logic signed [FIXED_WIDTH-1:0] y_o,
    output logic signed [FIXED_WIDTH-1:0] z_o
);

    logic signed [FIXED_WIDTH-1:0] x_sh;
    logic signed [FIXED_WIDTH-1:0] y_sh;
    logic signed [FIXED_WIDTH-1:0] dz;

    // Add/subtract shifted cross terms; x update depends on the coordinate system
    always_comb begin
        x_sh = x_i >>> shift_i;
        y_sh = y_i >>> shift_i;
        dz   = signed'(delta_z_i);
        x_o  = x_i;
        if (is_sigma_positive_i) begin
            y_o = y_i + x_sh;
            z_o = z_i - dz;
            if (mode_i == CIRCULAR_MODE)   x_o = x_i - y_sh;
            if (mode_i == HYPERBOLIC_MODE) x_o = x_i + y_sh;
        end else begin
            y_o = y_i - x_sh;
            z_o = z_i + dz;
            if (mode_i == CIRCULAR_MODE)   x_o = x_i + y_sh;
            if (mode_i == HYPERBOLIC_MODE) x_o = x_i - y_sh;
        end
    end

endmodule

// File: rtl/cordic_sequencer.sv
// rtl/cordic_sequencer.sv - multi-cycle controller around one CORDIC iteration stage
module cordic_sequencer
    import cordic_pkg::*;
#(
    parameter int FIXED_WIDTH = 16,
    parameter int ITERATIONS  = 14
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   abort,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [1:0]             in_mode,
    input  logic                   in_vectoring,
    input  logic [FIXED_WIDTH-1:0] in_x,
    input  logic [FIXED_WIDTH-1:0] in_y,
    input  logic [FIXED_WIDTH-1:0] in_z,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [FIXED_WIDTH-1:0] out_x,
    output logic [FIXED_WIDTH-1:0] out_y,
    output logic [FIXED_WIDTH-1:0] out_z,
    output logic                   out_err,
    output logic                   busy
);

    localparam int SHW = $clog2(ITERATIONS) + 1;

    if (FIXED_WIDTH != 16) begin : g_bad_width
        $error("cordic_sequencer: FIXED_WIDTH must be 16");
    end
    if (ITERATIONS < 1 || ITERATIONS > 14) begin : g_bad_iter
        $error("cordic_sequencer: ITERATIONS must be 1..14");
    end

    state_e state_q, state_d;
    logic signed [FIXED_WIDTH-1:0] x_q, y_q, z_q;
    logic signed [FIXED_WIDTH-1:0] x_nx, y_nx, z_nx;
    logic [SHW-1:0]         step_q;
    logic [SHW-1:0]         shift_w;
    logic [FIXED_WIDTH-1:0] delta_w;
    logic [1:0]             mode_q;
    logic                   vec_q;
    logic                   err_q;
    logic                   sigma_pos;
    logic                   accept;
    logic                   last_step;

    assign accept    = (state_q == ST_IDLE) && in_valid && !abort;
    assign last_step = (step_q == SHW'(ITERATIONS - 1));

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Next-state: abort wins over both handshakes
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept) state_d = (in_mode == INVALID_MODE) ? ST_DONE : ST_RUN;
            ST_RUN:  if (abort) state_d = ST_IDLE;
                     else if (last_step) state_d = ST_DONE;
            ST_DONE: if (abort || out_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Handshake/status outputs decoded from the state register only
    always_comb begin
        in_ready  = (state_q == ST_IDLE);
        busy      = (state_q == ST_RUN);
        out_valid = (state_q == ST_DONE);
    end

    // Operand latch on accept, then one micro-rotation per RUN cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_q    <= '0;
            y_q    <= '0;
            z_q    <= '0;
            step_q <= '0;
            mode_q <= CIRCULAR_MODE;
            vec_q  <= 1'b0;
            err_q  <= 1'b0;
        end else if (accept) begin
            step_q <= '0;
            mode_q <= in_mode;
            vec_q  <= in_vectoring;
            if (in_mode == INVALID_MODE) begin
                x_q   <= '0;
                y_q   <= '0;
                z_q   <= '0;
                err_q <= 1'b1;
            end else begin
                x_q   <= in_x;
                y_q   <= in_y;
                z_q   <= in_z;
                err_q <= 1'b0;
            end
        end else if (state_q == ST_RUN && !abort) begin
            x_q    <= x_nx;
            y_q    <= y_nx;
            z_q    <= z_nx;
            step_q <= step_q + 1'b1;
        end
    end

    // Shift schedule, angle constant and rotation direction for the current step
    always_comb begin
        shift_w = (mode_q == HYPERBOLIC_MODE) ? SHW'(hyp_shift(5'(step_q))) : step_q;
        case (mode_q)
            CIRCULAR_MODE:   delta_w = atan_delta(5'(shift_w));
            HYPERBOLIC_MODE: delta_w = atanh_delta(5'(shift_w));
            default:         delta_w = linear_delta(5'(shift_w));
        endcase
        sigma_pos = vec_q ? y_q[FIXED_WIDTH-1] : !z_q[FIXED_WIDTH-1];
    end

    cordic_iteration #(
        .FIXED_WIDTH (FIXED_WIDTH),
        .SHIFT_WIDTH (SHW)
    ) u_iter (
        .x_i                 (x_q),
        .y_i                 (y_q),
        .z_i                 (z_q),
        .shift_i             (shift_w),
        .delta_z_i           (delta_w),
        .mode_i              (mode_q),
        .is_sigma_positive_i (sigma_pos),
        .x_o                 (x_nx),
        .y_o                 (y_nx),
        .z_o                 (z_nx)
    );

    assign out_x   = x_q;
    assign out_y   = y_q;
    assign out_z   = z_q;
    assign out_err = err_q;

endmodule

// File: tb/tb_cordic_sequencer.sv
// tb/tb_cordic_sequencer.sv - directed self-checking bench for cordic_sequencer
module tb_cordic_sequencer;

    logic        clk = 1'b0;
    logic        rst, abort, in_valid, in_vectoring, out_ready;
    logic [1:0]  in_mode;
    logic [15:0] in_x, in_y, in_z;
    logic        in_ready, out_valid, out_err, busy;
    logic [15:0] out_x, out_y, out_z;

    int n_assert = 0;
    int n_fail   = 0;
    int shift_log[$];
    int exp_sh[14];
    int lat, rx, ry, rz, cnt4;

    always #5 clk = ~clk;

    cordic_sequencer #(.FIXED_WIDTH(16), .ITERATIONS(14)) dut (
        .clk          (clk),
        .rst          (rst),
        .abort        (abort),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_mode      (in_mode),
        .in_vectoring (in_vectoring),
        .in_x         (in_x),
        .in_y         (in_y),
        .in_z         (in_z),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_x        (out_x),
        .out_y        (out_y),
        .out_z        (out_z),
        .out_err      (out_err),
        .busy         (busy)
    );

    task automatic check(input string tag, input int obs, input int exp, input int tol);
        int d;
        d = obs - exp;
        if (d < 0) d = -d;
        n_assert++;
        assert (d <= tol) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d (tol %0d)", tag, obs, exp, tol);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_op(input logic [1:0] m, input logic v, input int x, input int y, input int z);
        in_mode      = m;
        in_vectoring = v;
        in_x         = 16'(x);
        in_y         = 16'(y);
        in_z         = 16'(z);
        in_valid     = 1'b1;
        check("accept_in_ready", int'(in_ready), 1, 0);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input int edges0, output int latency);
        int edges;
        edges = edges0;
        shift_log.delete();
        while (!out_valid && edges < 40) begin
            if (busy) shift_log.push_back(int'(dut.shift_w));
            tick();
            edges++;
        end
        check("done_timeout", int'(out_valid), 1, 0);
        latency = edges + 1;
    endtask

    task automatic read_result(input int hold, output int ox, output int oy, output int oz);
        int sx;
        sx = int'($signed(out_x));
        for (int i = 0; i < hold; i++) begin
            tick();
            check("hold_valid", int'(out_valid), 1, 0);
            check("hold_in_ready", int'(in_ready), 0, 0);
            check("hold_x_stable", int'($signed(out_x)), sx, 0);
        end
        ox = int'($signed(out_x));
        oy = int'($signed(out_y));
        oz = int'($signed(out_z));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("post_accept_valid", int'(out_valid), 0, 0);
        check("post_accept_in_ready", int'(in_ready), 1, 0);
    endtask

    initial begin
        exp_sh = '{1, 2, 3, 4, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13};
        rst = 1'b1; abort = 1'b0; in_valid = 1'b0; in_vectoring = 1'b0; out_ready = 1'b0;
        in_mode = 2'b00; in_x = '0; in_y = '0; in_z = '0;
        tick();
        tick();
        check("rst_in_ready", int'(in_ready), 1, 0);
        check("rst_out_valid", int'(out_valid), 0, 0);
        check("rst_busy", int'(busy), 0, 0);
        check("rst_out_err", int'(out_err), 0, 0);
        check("rst_out_x", int'(out_x), 0, 0);
        check("rst_out_y", int'(out_y), 0, 0);
        check("rst_out_z", int'(out_z), 0, 0);
        rst = 1'b0;
        tick();

        // Circular rotation by pi/6, with a stray in_valid pulse during RUN
        start_op(2'b00, 1'b0, 4975, 0, 4289);
        tick(); tick(); tick();
        in_valid = 1'b1; in_mode = 2'b11; in_x = 16'd1234;
        check("run_in_ready", int'(in_ready), 0, 0);
        check("run_busy", int'(busy), 1, 0);
        tick();
        in_valid = 1'b0;
        check("pulse_ignored_busy", int'(busy), 1, 0);
        wait_done(4, lat);
        check("circ_rot_latency", lat, 15, 0);
        check("circ_rot_err", int'(out_err), 0, 0);
        read_result(0, rx, ry, rz);
        check("circ_rot_x", rx, 7094, 12);
        check("circ_rot_y", ry, 4096, 12);
        check("circ_rot_z", rz, 0, 12);

        // Circular vectoring with consumer stalling for 5 cycles
        start_op(2'b00, 1'b1, 8192, 8192, 0);
        wait_done(0, lat);
        read_result(5, rx, ry, rz);
        check("circ_vec_x", rx, 19078, 12);
        check("circ_vec_y", ry, 0, 12);
        check("circ_vec_z", rz, 6434, 12);

        // Linear vectoring: z = y/x
        start_op(2'b01, 1'b1, 16384, 8192, 0);
        wait_done(0, lat);
        read_result(0, rx, ry, rz);
        check("lin_vec_x", rx, 16384, 0);
        check("lin_vec_z", rz, 4096, 2);

        // Invalid mode returns zeros with error after one cycle
        start_op(2'b11, 1'b0, 100, 200, 300);
        wait_done(0, lat);
        check("inv_latency", lat, 1, 0);
        check("inv_err", int'(out_err), 1, 0);
        read_result(0, rx, ry, rz);
        check("inv_x", rx, 0, 0);
        check("inv_y", ry, 0, 0);
        check("inv_z", rz, 0, 0);

        // Linear rotation: y = x*z, error flag cleared again
        start_op(2'b01, 1'b0, 8192, 0, 12288);
        wait_done(0, lat);
        check("lin_rot_err", int'(out_err), 0, 0);
        check("lin_rot_latency", lat, 15, 0);
        read_result(0, rx, ry, rz);
        check("lin_rot_x", rx, 8192, 0);
        check("lin_rot_y", ry, 12288, 2);

        // Hyperbolic rotation: cosh/sinh(0.5), shift schedule probed
        start_op(2'b10, 1'b0, 9892, 0, 4096);
        wait_done(0, lat);
        check("hyp_shift_count", shift_log.size(), 14, 0);
        cnt4 = 0;
        for (int i = 0; i < shift_log.size(); i++) begin
            if (shift_log[i] == 4) cnt4++;
            if (i < 14) check("hyp_shift_seq", shift_log[i], exp_sh[i], 0);
        end
        check("hyp_shift_four_twice", cnt4, 2, 0);
        read_result(0, rx, ry, rz);
        check("hyp_rot_x", rx, 9237, 16);
        check("hyp_rot_y", ry, 4269, 16);

        // Abort after six iterations
        start_op(2'b00, 1'b0, 4975, 0, 4289);
        for (int i = 0; i < 6; i++) tick();
        check("abort_step", int'(dut.step_q), 6, 0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_busy", int'(busy), 0, 0);
        check("abort_in_ready", int'(in_ready), 1, 0);
        check("abort_out_valid", int'(out_valid), 0, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("abort_no_valid", int'(out_valid), 0, 0);
        end

        // Operation after abort
        start_op(2'b01, 1'b0, 8192, 0, 12288);
        wait_done(0, lat);
        read_result(0, rx, ry, rz);
        check("after_abort_y", ry, 12288, 2);

        // Asynchronous reset between edges mid-RUN
        start_op(2'b01, 1'b1, 16384, 8192, 0);
        tick(); tick(); tick();
        #2;
        rst = 1'b1;
        #1;
        check("arst_in_ready", int'(in_ready), 1, 0);
        check("arst_busy", int'(busy), 0, 0);
        check("arst_out_valid", int'(out_valid), 0, 0);
        check("arst_out_err", int'(out_err), 0, 0);
        check("arst_out_x", int'(out_x), 0, 0);
        check("arst_out_y", int'(out_y), 0, 0);
        check("arst_out_z", int'(out_z), 0, 0);
        #1;
        rst = 1'b0;
        tick();

        // Operation after reset
        start_op(2'b00, 1'b1, 8192, 8192, 0);
        wait_done(0, lat);
        check("after_rst_latency", lat, 15, 0);
        read_result(0, rx, ry, rz);
        check("after_rst_x", rx, 19078, 12);
        check("after_rst_z", rz, 6434, 12);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
